// File: rtl/alu_operand_deser.sv
// ---------------------------------------------------------------------------
// alu_operand_deser
//
// Serial front end for the shift-register ALU. It collects a start-framed,
// even-parity bit stream and rebuilds the opcode and the A/B operands. The
// result is held in a one-entry slot with a valid/ready handshake.
//
// Frame on the wire, in order:
//   start(1) | op MSB-first | A MSB-first | B MSB-first | parity
// The parity bit makes the total count of ones across data + parity even.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears all state
//   en         global enable; 0 freezes receive state (handshake still runs)
//   sin        serial data bit
//   sin_valid  sin carries a bit this cycle
//   out_ready  consumer accepts the held operands
//   op, A, B   assembled opcode / operands (registered)
//   out_valid  slot holds an unconsumed frame
//   par_err    one-cycle pulse: parity failure, frame dropped
//   overrun    one-cycle pulse: good frame dropped because the slot was full
// ---------------------------------------------------------------------------
module alu_operand_deser #(
    parameter int OPW = 2,
    parameter int DW  = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           sin,
    input  logic           sin_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] op,
    output logic [DW-1:0]  A,
    output logic [DW-1:0]  B,
    output logic           out_valid,
    output logic           par_err,
    output logic           overrun
);

    localparam int N  = OPW + 2 * DW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [N-1:0]    shift_reg;
    logic            par_acc_reg;
    logic [OPW-1:0]  op_reg;
    logic [DW-1:0]   a_reg;
    logic [DW-1:0]   b_reg;
    logic            out_valid_reg;
    logic            par_err_reg;
    logic            overrun_reg;

    logic            bit_accept;
    logic            slot_free;
    logic            par_ok;

    assign bit_accept = en & sin_valid;
    // A consumer draining the slot on the same edge frees it for a new frame.
    assign slot_free  = ~out_valid_reg | out_ready;
    // Even parity: the received parity bit must equal XOR of the data bits.
    assign par_ok     = (sin == par_acc_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            par_acc_reg   <= 1'b0;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            out_valid_reg <= 1'b0;
            par_err_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            par_err_reg <= 1'b0;
            overrun_reg <= 1'b0;

            // Handshake runs regardless of en; a reload below overrides it.
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end

            if (bit_accept) begin
                case (state_reg)
                    IDLE: begin
                        // Zeros between frames are line idle and are ignored.
                        if (sin) begin
                            state_reg   <= DATA;
                            cnt_reg     <= '0;
                            par_acc_reg <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_reg   <= {shift_reg[N-2:0], sin};
                        par_acc_reg <= par_acc_reg ^ sin;
                        if (cnt_reg == CNT_LAST) begin
                            cnt_reg   <= '0;
                            state_reg <= PAR;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    PAR: begin
                        state_reg <= IDLE;
                        // Parity failure wins over overrun: a bad frame never
                        // counts as a lost good frame.
                        if (!par_ok) begin
                            par_err_reg <= 1'b1;
                        end else if (slot_free) begin
                            op_reg        <= shift_reg[N-1 -: OPW];
                            a_reg         <= shift_reg[2*DW-1 -: DW];
                            b_reg         <= shift_reg[DW-1:0];
                            out_valid_reg <= 1'b1;
                        end else begin
                            overrun_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign op        = op_reg;
    assign A         = a_reg;
    assign B         = b_reg;
    assign out_valid = out_valid_reg;
    assign par_err   = par_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: doc/alu_operand_deser.md
# alu_operand_deser

Serial front end for the shift-register ALU. It receives a start-framed, even-parity bit stream and reassembles it into the op/A/B operand set that the ALU consumes. Assembled operands are presented on a one-entry holding register with a valid/ready handshake. Parity failures and overruns are flagged and the offending frame is dropped.

## Interface
- OPW, 2, opcode width
- DW, 3, operand width (A and B each)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; clears all state
- en  input  1  global enable; 0 freezes FSM, counter and shift register
- sin  input  1  serial data bit
- sin_valid  input  1  sin carries a bit this cycle
- out_ready  input  1  consumer accepts held operands
- op  output  OPW  assembled opcode
- A  output  DW  assembled operand A
- B  output  DW  assembled operand B
- out_valid  output  1  op/A/B hold an unconsumed frame
- par_err  output  1  one-cycle pulse: parity failure, frame dropped
- overrun  output  1  one-cycle pulse: good frame dropped because the slot was full

## Operation
- A bit is accepted on a rising edge with en=1 and sin_valid=1. No other edge advances receive state.
- Frame layout, in order: start bit (1), then op MSB-first, A MSB-first, B MSB-first (N = OPW+2*DW = 8 bits), then the parity bit.
- Parity is even: the parity bit is chosen so the data bits plus the parity bit contain an even number of ones.
- FSM states:
  - IDLE: an accepted bit of 1 goes to DATA with cnt=0. An accepted bit of 0 is ignored.
  - DATA: each accepted bit shifts into the shift register and increments cnt. When cnt reaches N-1 and that bit is accepted, go to PAR.
  - PAR: the accepted bit is checked against the running XOR of the data bits. The FSM always returns to IDLE.
- Frame completion, evaluated on the PAR acceptance edge:
  - Parity bad: pulse par_err. The slot is unchanged.
  - Parity good and the slot is free: load op/A/B and set out_valid. The slot is free when out_valid=0, or when out_valid=1 and out_ready=1 on the same edge.
  - Parity good and the slot is full: pulse overrun. op/A/B are unchanged and out_valid stays 1.
- Handshake: out_valid clears on an edge where out_valid=1 and out_ready=1, unless a good frame reloads on the same edge, in which case it stays 1 with the new data. out_ready is ignored when out_valid=0.
- en=0: FSM, cnt, shift register and parity accumulator hold. The handshake still operates: out_valid may clear via out_ready. No pulses are generated.
- sin_valid gaps mid-frame only stall reception. Frames are never aborted except by reset.
- Parity error takes precedence over overrun; at most one of the two pulses per frame.

## Timing
- Reset values: op=0, A=0, B=0, out_valid=0, par_err=0, overrun=0, state=IDLE, cnt=0.
- Reset is asynchronous, including mid-frame. The partial frame is lost and the first bit after release is treated in IDLE.
- Latency: out_valid, par_err and overrun are registered and appear after the edge that accepts the parity bit. With back-to-back bits this is 10 accepted edges from the start bit.
- par_err and overrun are high for exactly one cycle.
- Back-to-back frames need no idle gap. The start bit of the next frame may be accepted on the edge immediately after the parity edge.
- op/A/B are stable while out_valid=1 and out_ready=0.

## Test plan
- Basic frame: sin = 1,0,1,0,0,1,0,0,1,1 (one bit per cycle, sin_valid=1, en=1, out_ready=0) -> after the 10th edge out_valid=1, op=01, A=001, B=001, par_err=0.
- Parity error: same frame with the last bit 0 -> par_err pulses for 1 cycle; out_valid stays 0; op/A/B stay 0.
- Overrun: send the basic frame with out_ready=0, then a second good frame 1,11,111,000,1 (op=11, A=111, B=000, parity=1) -> overrun pulses; op/A/B remain 01/001/001.
- Handshake: hold out_ready=1 while the second frame completes -> out_valid stays 1 with op=11, A=111, B=000; no overrun. Then out_ready=1 for one more cycle -> out_valid=0.
- Stall/enable: in the basic frame, drop en to 0 for 2 cycles after the 4th data bit and drop sin_valid for 3 cycles later -> same result as the basic frame; no pulses during stalls.
- Reset mid-frame: assert rst_n=0 after the 5th data bit, release, then send the basic frame -> all outputs 0 during reset; the basic frame decodes correctly afterwards.
